// File: rtl/bist_pkg.sv
// Shared March C- definitions: sequencer state, element encoding and the
// per-element op table (op count, address direction, read/write and data value).
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_e;

  // Index of the last op in an element (every element has one or two ops).
  function automatic logic elem_last_op(input elem_e e);
    case (e)
      M0, M5:  elem_last_op = 1'b0;
      default: elem_last_op = 1'b1;
    endcase
  endfunction

  // 1 = element walks addresses downwards.
  function automatic logic elem_down(input elem_e e);
    case (e)
      M3, M4:  elem_down = 1'b1;
      default: elem_down = 1'b0;
    endcase
  endfunction

  // 1 = op is a write, 0 = op is a read.
  function automatic logic op_is_write(input elem_e e, input logic op);
    case (e)
      M0:      op_is_write = 1'b1;
      M5:      op_is_write = 1'b0;
      default: op_is_write = op;
    endcase
  endfunction

  // Data bit written, or expected on read, by an op.
  function automatic logic op_value(input elem_e e, input logic op);
    case (e)
      M1, M3:  op_value = op;
      M2, M4:  op_value = ~op;
      default: op_value = 1'b0;
    endcase
  endfunction

  function automatic elem_e next_elem(input elem_e e);
    case (e)
      M0:      next_elem = M1;
      M1:      next_elem = M2;
      M2:      next_elem = M3;
      M3:      next_elem = M4;
      M4:      next_elem = M5;
      default: next_elem = M5;
    endcase
  endfunction

endpackage

// File: rtl/march_addr_ctr.sv
// Up/down address counter with synchronous load and count enable.
// Ports: clk, reset (async, active-high), load/load_val, en, down,
//        addr (registered), at_zero_c / at_max_c (combinational end flags).
// First/last of a walk are at_zero_c/at_max_c for upward walks, swapped for downward.
module march_addr_ctr #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              at_zero_c,
  output logic              at_max_c
);

  // Load wins over count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (en) begin
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign at_zero_c = (addr == '0);
  assign at_max_c  = (addr == '1);

endmodule

// File: rtl/march_sequencer.sv
// March C- BIST sequencer for a single-port RAM, stepped by clk_en.
// Ports: clk, reset (async, active-high), clk_en (step strobe), start,
//        ram_addr/ram_we/ram_wdata/ram_rdata (RAM under test),
//        busy, done, fail, fail_addr (BIST status).
module march_sequencer
  import bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);

  state_e            state, state_nxt;
  elem_e             elem_q, elem_d;
  logic              op_q, op_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

  logic              ctr_load, ctr_en, ctr_down;
  logic [ADDR_W-1:0] ctr_load_val;
  logic              at_zero_c, at_max_c;

  logic              cur_write, cur_value, at_last_addr, read_miss;
  logic [DATA_W-1:0] cur_word;

  march_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .load_val  (ctr_load_val),
    .en        (ctr_en),
    .down      (ctr_down),
    .addr      (ram_addr),
    .at_zero_c (at_zero_c),
    .at_max_c  (at_max_c)
  );

  // Current op decode.
  assign cur_write    = op_is_write(elem_q, op_q);
  assign cur_value    = op_value(elem_q, op_q);
  assign cur_word     = {DATA_W{cur_value}};
  assign at_last_addr = elem_down(elem_q) ? at_zero_c : at_max_c;
  assign read_miss    = !cur_write && (ram_rdata != cur_word);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      elem_q      <= M0;
      op_q        <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state       <= state_nxt;
      elem_q      <= elem_d;
      op_q        <= op_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  // Next-state, op sequencing and compare.
  always_comb begin
    state_nxt    = state;
    elem_d       = elem_q;
    op_d         = op_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_en       = 1'b0;
    ctr_down     = elem_down(elem_q);

    case (state)
      RUN: begin
        if (clk_en) begin
          if (read_miss) begin
            fail_d      = 1'b1;
            fail_addr_d = ram_addr;
            state_nxt   = DONE;
          end else if (op_q != elem_last_op(elem_q)) begin
            op_d = 1'b1;
          end else begin
            op_d = 1'b0;
            if (!at_last_addr) begin
              ctr_en = 1'b1;
            end else if (elem_q == M5) begin
              state_nxt = DONE;
            end else begin
              // Next element restarts at its own start address.
              elem_d       = next_elem(elem_q);
              ctr_load     = 1'b1;
              ctr_load_val = elem_down(next_elem(elem_q)) ? '1 : '0;
            end
          end
        end
      end
      default: begin
        // IDLE and DONE: start launches a fresh run; no op this cycle.
        if (start) begin
          state_nxt    = RUN;
          elem_d       = M0;
          op_d         = 1'b0;
          fail_d       = 1'b0;
          fail_addr_d  = '0;
          ctr_load     = 1'b1;
          ctr_load_val = '0;
        end
      end
    endcase
  end

  // Write strobe is deliberately combinational: one clk cycle per enabled write.
  assign ram_we    = (state == RUN) && clk_en && cur_write;
  assign ram_wdata = (state == RUN) ? cur_word : '0;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_march_sequencer.sv
// Self-checking bench for march_sequencer: a RAM model with optional faults,
// a March C- op list built from the element table, and a predicted outcome.
module tb_march_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, clk_en, start;
  logic [AW-1:0] ram_addr, fail_addr;
  logic          ram_we, busy, done, fail;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [N];
  int            fault_sel = 0;  // 0 none, 1 stuck-at-1 bit0 @5, 2 coupling 3->9

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int addr;
    bit wr;
    bit val;
  } op_t;
  op_t ops[$];

  always #5 clk = ~clk;

  march_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr)
  );

  function automatic logic [DW-1:0] read_fault(int f, int a, logic [DW-1:0] v);
    if (f == 1 && a == 5) return v | DW'(1);
    return v;
  endfunction

  // RAM under test: zero-latency read, write at the clock edge.
  assign ram_rdata = read_fault(fault_sel, int'(ram_addr), mem[ram_addr]);

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      if (fault_sel == 2 && ram_addr == AW'(3) && ram_wdata == {DW{1'b1}})
        mem[9] <= {DW{1'b1}};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Full March C- op list from the element table.
  task automatic build_ops();
    int nops  [6] = '{1, 2, 2, 2, 2, 1};
    bit dn    [6] = '{0, 0, 0, 1, 1, 0};
    bit wr_t  [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit val_t [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    op_t o;
    ops.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < int'(N); i++)
        for (int k = 0; k < nops[e]; k++) begin
          o.addr = dn[e] ? int'(N) - 1 - i : i;
          o.wr   = wr_t[e][k];
          o.val  = val_t[e][k];
          ops.push_back(o);
        end
  endtask

  // Play the op list on an idealised faulty RAM to predict the outcome.
  task automatic predict(input int f, output int n, output bit fl, output int fa);
    logic [DW-1:0] m [N];
    logic [DW-1:0] rd;
    for (int i = 0; i < int'(N); i++) m[i] = '0;
    n = ops.size(); fl = 0; fa = 0;
    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i].wr) begin
        m[ops[i].addr] = {DW{ops[i].val}};
        if (f == 2 && ops[i].addr == 3 && ops[i].val) m[9] = {DW{1'b1}};
      end else begin
        rd = read_fault(f, ops[i].addr, m[ops[i].addr]);
        if (rd != {DW{ops[i].val}}) begin
          n = i + 1; fl = 1; fa = ops[i].addr;
          break;
        end
      end
    end
  endtask

  function automatic bit en_pattern(int mode, int cyc);
    case (mode)
      0:       return (cyc % 4) == 3;
      1:       return $urandom_range(0, 2) == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(ram_addr),  0);
    check({tag, "_we"},    32'(ram_we),    0);
    check({tag, "_wdata"}, 32'(ram_wdata), 0);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_done"},  32'(done),      0);
    check({tag, "_fail"},  32'(fail),      0);
    check({tag, "_faddr"}, 32'(fail_addr), 0);
  endtask

  // One test run; abort_at >= 0 pulls reset just before that enabled op.
  task automatic run_march(input int f, input int mode, input int abort_at, input string tag);
    int n, fa, k, cyc;
    bit fl, e;
    fault_sel = f;
    predict(f, n, fl, fa);

    // start together with clk_en: transition only, no op.
    @(negedge clk);
    start = 1'b1; clk_en = 1'b1;
    #1 check({tag, "_start_we"}, 32'(ram_we), 0);

    k = 0; cyc = 0;
    while (k < n && cyc < 4000) begin
      @(negedge clk);
      start  = ($urandom_range(0, 7) == 0);
      e      = en_pattern(mode, cyc);
      clk_en = e;
      cyc++;
      if (k == abort_at && e) begin
        reset = 1'b1; clk_en = 1'b0; start = 1'b0;
        #1 check_reset_outputs({tag, "_abort"});
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      #1;
      if (cyc == 1) begin
        check({tag, "_busy0"},  32'(busy),      1);
        check({tag, "_done0"},  32'(done),      0);
        check({tag, "_fail0"},  32'(fail),      0);
        check({tag, "_faddr0"}, 32'(fail_addr), 0);
        check({tag, "_addr0"},  32'(ram_addr),  0);
      end
      if (e) begin
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_addr"}, 32'(ram_addr), 32'(ops[k].addr));
        check({tag, "_we"},   32'(ram_we),   32'(ops[k].wr));
        if (ops[k].wr) check({tag, "_wdata"}, 32'(ram_wdata), 32'({DW{ops[k].val}}));
        k++;
      end else begin
        check({tag, "_we_idle"}, 32'(ram_we), 0);
      end
    end
    if (k < n) check({tag, "_timeout_ops"}, 32'(k), 32'(n));

    @(negedge clk);
    start = 1'b0; clk_en = 1'b0;
    #1;
    check({tag, "_busy_end"},  32'(busy),      0);
    check({tag, "_done_end"},  32'(done),      1);
    check({tag, "_fail_end"},  32'(fail),      32'(fl));
    check({tag, "_faddr_end"}, 32'(fail_addr), 32'(fa));

    // No RAM activity while parked in DONE.
    repeat (6) begin
      @(negedge clk);
      clk_en = 1'($urandom_range(0, 1));
      #1;
      check({tag, "_we_done"},   32'(ram_we), 0);
      check({tag, "_done_hold"}, 32'(done),   1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clk_en = 1'b0;
    build_ops();
    #1 check_reset_outputs("reset");
    #20;
    @(negedge clk);
    reset = 1'b0;

    // clk_en in IDLE must do nothing.
    repeat (8) begin
      @(negedge clk);
      clk_en = 1'b1;
      #1;
      check("idle_we",   32'(ram_we), 0);
      check("idle_busy", 32'(busy),   0);
    end
    clk_en = 1'b0;

    run_march(0, 0, -1, "good_div4");
    run_march(1, 1, -1, "stuck5");
    run_march(2, 1, -1, "coupling");
    run_march(0, 1, 70, "abort");
    run_march(0, 0, -1, "after_abort");
    run_march(0, 2, -1, "cont_a");
    run_march(0, 2, -1, "cont_b");
    run_march(1, 2, -1, "stuck_cont");
    run_march(0, 1, -1, "good_rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
